// File: rtl/dm_pkg.sv
// DMI shared types: op/response encodings
// and request/response bundles.
package DM;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_OK   = 2'd0,
    RESP_RSVD = 2'd1,
    RESP_FAIL = 2'd2,
    RESP_BUSY = 2'd3
  } dmi_resp_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    dmi_op_e               op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    dmi_resp_e             resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_addr_decode.sv
// Region decode: address -> hit, one-hot
// target, offset from the target base.
module dmi_addr_decode #(
  parameter int ADDR_W = 7,
  parameter int N_TGT  = 2,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = {7'h10, 7'h38},
  parameter logic [N_TGT*ADDR_W-1:0] TGT_SIZE = {7'h28, 7'h08}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [N_TGT-1:0]  onehot,
  output logic [ADDR_W-1:0] offset
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] size;
  logic [ADDR_W:0]   lo;
  logic [ADDR_W:0]   hi;

  // Target 0 is the leftmost slice; walk down so the lowest index wins.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    offset = '0;
    base   = '0;
    size   = '0;
    lo     = '0;
    hi     = '0;
    for (int k = N_TGT - 1; k >= 0; k--) begin
      base = TGT_BASE[(N_TGT-1-k)*ADDR_W +: ADDR_W];
      size = TGT_SIZE[(N_TGT-1-k)*ADDR_W +: ADDR_W];
      lo   = {1'b0, base};
      hi   = lo + {1'b0, size};
      if ({1'b0, addr} >= lo && {1'b0, addr} < hi) begin
        hit    = 1'b1;
        onehot = N_TGT'(1) << k;
        offset = addr - base;
      end
    end
  end

endmodule

// File: rtl/dmi_dispatch.sv
// DMI request dispatcher: decodes, issues to
// one target, waits with timeout, responds.
module dmi_dispatch
  import DM::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int N_TGT   = 2,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = {7'h10, 7'h38},
  parameter logic [N_TGT*ADDR_W-1:0] TGT_SIZE = {7'h28, 7'h08},
  parameter int TIMEOUT = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  input  logic [ADDR_W-1:0]       dmi_req_addr_i,
  input  logic [1:0]              dmi_req_op_i,
  input  logic [DATA_W-1:0]       dmi_req_data_i,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,
  output logic [DATA_W-1:0]       dmi_resp_data_o,
  output logic [1:0]              dmi_resp_resp_o,
  output logic [N_TGT-1:0]        tgt_req_o,
  input  logic [N_TGT-1:0]        tgt_gnt_i,
  output logic                    tgt_we_o,
  output logic [ADDR_W-1:0]       tgt_addr_o,
  output logic [DATA_W-1:0]       tgt_wdata_o,
  input  logic [N_TGT-1:0]        tgt_rvalid_i,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata_i,
  input  logic [N_TGT-1:0]        tgt_err_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic [N_TGT-1:0]  sel;
  logic              rd_op;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              expired;
  logic [DATA_W-1:0] rsp_data;
  dmi_resp_e         rsp_code;

  logic              dec_hit;
  logic [N_TGT-1:0]  dec_oh;
  logic [ADDR_W-1:0] dec_off;

  logic              gnt;
  logic              rvalid;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] done_data;
  dmi_resp_e         done_code;
  dmi_op_e           op;

  dmi_addr_decode #(
    .ADDR_W   (ADDR_W),
    .N_TGT    (N_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_SIZE (TGT_SIZE)
  ) u_dec (
    .addr   (dmi_req_addr_i),
    .hit    (dec_hit),
    .onehot (dec_oh),
    .offset (dec_off)
  );

  assign op      = dmi_op_e'(dmi_req_op_i);
  assign gnt     = |(tgt_gnt_i & sel);
  assign rvalid  = |(tgt_rvalid_i & sel);
  assign err     = |(tgt_err_i & sel);
  assign cnt_nxt = cnt + 1'b1;
  assign expired = cnt_nxt >= CNT_LAST;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_TGT; k++) begin
      if (sel[k]) begin
        rdata = rdata | tgt_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign done_code = err ? RESP_FAIL : RESP_OK;
  assign done_data = (rd_op && !err) ? rdata : '0;

  assign dmi_req_ready_o  = state == S_IDLE;
  assign dmi_resp_valid_o = state == S_RESP;
  assign dmi_resp_data_o  = rsp_data;
  assign dmi_resp_resp_o  = rsp_code;
  assign tgt_req_o        = (state == S_ISSUE) ? sel : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      sel         <= '0;
      rd_op       <= 1'b0;
      cnt         <= '0;
      rsp_data    <= '0;
      rsp_code    <= RESP_OK;
      tgt_we_o    <= 1'b0;
      tgt_addr_o  <= '0;
      tgt_wdata_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (dmi_req_valid_i) begin
            tgt_we_o    <= (op == OP_WRITE);
            rd_op       <= (op == OP_READ);
            tgt_addr_o  <= dec_off;
            tgt_wdata_o <= dmi_req_data_i;
            sel         <= dec_oh;
            cnt         <= '0;
            rsp_data    <= '0;
            rsp_code    <= RESP_FAIL;
            state       <= S_RESP;
            unique case (op)
              OP_NOP: rsp_code <= RESP_OK;
              OP_READ, OP_WRITE: begin
                if (dec_hit) begin
                  state <= S_ISSUE;
                end
              end
              OP_RSVD: ;
            endcase
          end
        end
        // A completion in the expiry cycle still wins.
        S_ISSUE: begin
          if (gnt && rvalid) begin
            state    <= S_RESP;
            rsp_code <= done_code;
            rsp_data <= done_data;
          end else if (gnt) begin
            state <= S_WAIT;
            cnt   <= cnt_nxt;
          end else if (expired) begin
            state    <= S_RESP;
            rsp_code <= RESP_BUSY;
            rsp_data <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            state    <= S_RESP;
            rsp_code <= done_code;
            rsp_data <= done_data;
          end else if (expired) begin
            state    <= S_RESP;
            rsp_code <= RESP_BUSY;
            rsp_data <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_RESP: begin
          if (dmi_resp_ready_i) begin
            state    <= S_IDLE;
            rsp_data <= '0;
            rsp_code <= RESP_OK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
